// File: rtl/upme_param_if.sv
// Bus interface for upme_param: control inputs (enable, direction, load)
// and the count/status outputs. Clock and reset stay plain ports on the block.
interface upme_param_if #(
    parameter int WIDTH = 3
);
    logic             eena;   // global enable
    logic             up;     // direction, 1 = up
    logic             eld;    // synchronous load strobe
    logic [WIDTH-1:0] ed;     // load value
    logic [WIDTH-1:0] sq;     // current count
    logic             tick;   // prescaler strobe, high with each new count
    logic             tc;     // terminal-count pulse
    logic [WIDTH:0]   oea;    // status bus {up, sq}

    // Master drives the controls (testbench or parent logic).
    modport master (
        output eena, up, eld, ed,
        input  sq, tick, tc, oea
    );

    // Slave is the counter itself.
    modport slave (
        input  eena, up, eld, ed,
        output sq, tick, tc, oea
    );
endinterface

// File: rtl/upme_param.sv
// upme_param: parametrised up/down modulo-MOD counter with a divide-by-DIV
// prescaler, synchronous clamped load and a one-cycle terminal-count pulse.
// Optional macro UPME_SAT_EN selects saturating instead of wrap-around
// counting at the ends of the range; the default build wraps.
module upme_param #(
    parameter int WIDTH = 3,   // counter width, MOD <= 2**WIDTH
    parameter int MOD   = 8,   // count modulus, 2..2**WIDTH
    parameter int DIV   = 4    // prescaler ratio, >= 1
) (
    input  logic         eck,  // clock, rising edge
    input  logic         er,   // asynchronous reset, active-high
    upme_param_if.slave  bus
);
    // Prescaler width: clog2(DIV), but never less than one bit.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]    P_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0]    P_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] SQ_MAX = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] SQ_ONE = WIDTH'(1);
    // One extra bit so MOD == 2**WIDTH is representable for the clamp test.
    localparam logic [WIDTH:0]   MOD_X  = (WIDTH + 1)'(MOD);

    logic [PW-1:0]    p_q, p_d;
    logic [WIDTH-1:0] sq_q, sq_d;
    logic             tick_q, tick_d;
    logic             tc_q, tc_d;

    // Next-state: load beats enable; otherwise advance the prescaler and step on its last phase.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        p_d    = p_q;
        sq_d   = sq_q;
        tick_d = 1'b0;
        tc_d   = 1'b0;

        if (bus.eld) begin
            // Clamp out-of-range load values so sq never leaves 0..MOD-1.
            sq_d = ({1'b0, bus.ed} >= MOD_X) ? SQ_MAX : bus.ed;
            p_d  = '0;
        end else if (bus.eena) begin
            if (p_q == P_LAST) begin
                p_d    = '0;
                tick_d = 1'b1;
                if (bus.up) begin
                    if (sq_q == SQ_MAX) begin
                        tc_d = 1'b1;
`ifdef UPME_SAT_EN
                        sq_d = sq_q;
`else
                        sq_d = '0;
`endif
                    end else begin
                        sq_d = sq_q + SQ_ONE;
                    end
                end else begin
                    if (sq_q == '0) begin
                        tc_d = 1'b1;
`ifdef UPME_SAT_EN
                        sq_d = sq_q;
`else
                        sq_d = SQ_MAX;
`endif
                    end else begin
                        sq_d = sq_q - SQ_ONE;
                    end
                end
            end else begin
                p_d = p_q + P_ONE;
            end
        end
    end

    // State register with asynchronous reset; reset clears count, prescaler and both pulses at once.
    always_ff @(posedge eck or posedge er) begin
        if (er) begin
            p_q    <= '0;
            sq_q   <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            p_q    <= p_d;
            sq_q   <= sq_d;
            tick_q <= tick_d;
            tc_q   <= tc_d;
        end
    end

    assign bus.sq   = sq_q;
    assign bus.tick = tick_q;
    assign bus.tc   = tc_q;
    // Direction is passed through combinationally; the count half is registered.
    assign bus.oea  = {bus.up, sq_q};

endmodule

// File: tb/tb_upme_param.sv
// Testbench for upme_param: three instances (MOD/DIV = 8/4, 5/4, 8/1) share
// one randomized stimulus stream and are compared every cycle against a
// behavioural model that counts enabled cycles and uses modulo arithmetic.
// Follows UPME_SAT_EN in the same way the design does.
module tb_upme_param;
    localparam int W = 3;
    localparam int N = 3;
    localparam int MODS [N] = '{8, 5, 8};
    localparam int DIVS [N] = '{4, 4, 1};

    logic         eck = 1'b0;
    logic         er  = 1'b0;
    logic         eena = 1'b0;
    logic         up   = 1'b1;
    logic         eld  = 1'b0;
    logic [W-1:0] ed   = '0;

    logic [W-1:0] sq_o   [N];
    logic         tick_o [N];
    logic         tc_o   [N];
    logic [W:0]   oea_o  [N];

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state per instance.
    int m_sq [N];
    int m_en [N];   // enabled cycles since the last step, load or reset
    int m_tick [N];
    int m_tc [N];

    always #5 eck = ~eck;

    upme_param_if #(.WIDTH(W)) bus0 ();
    upme_param_if #(.WIDTH(W)) bus1 ();
    upme_param_if #(.WIDTH(W)) bus2 ();

    upme_param #(.WIDTH(W), .MOD(8), .DIV(4)) dut0 (.eck(eck), .er(er), .bus(bus0));
    upme_param #(.WIDTH(W), .MOD(5), .DIV(4)) dut1 (.eck(eck), .er(er), .bus(bus1));
    upme_param #(.WIDTH(W), .MOD(8), .DIV(1)) dut2 (.eck(eck), .er(er), .bus(bus2));

    assign bus0.eena = eena;  assign bus0.up = up;  assign bus0.eld = eld;  assign bus0.ed = ed;
    assign bus1.eena = eena;  assign bus1.up = up;  assign bus1.eld = eld;  assign bus1.ed = ed;
    assign bus2.eena = eena;  assign bus2.up = up;  assign bus2.eld = eld;  assign bus2.ed = ed;

    assign sq_o[0] = bus0.sq;  assign tick_o[0] = bus0.tick;  assign tc_o[0] = bus0.tc;  assign oea_o[0] = bus0.oea;
    assign sq_o[1] = bus1.sq;  assign tick_o[1] = bus1.tick;  assign tc_o[1] = bus1.tc;  assign oea_o[1] = bus1.oea;
    assign sq_o[2] = bus2.sq;  assign tick_o[2] = bus2.tick;  assign tc_o[2] = bus2.tc;  assign oea_o[2] = bus2.oea;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sq[i] = 0; m_en[i] = 0; m_tick[i] = 0; m_tc[i] = 0;
        end
    endtask

    // Apply one clock edge to the model using the inputs present at that edge.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            m_tick[i] = 0;
            m_tc[i]   = 0;
            if (er) begin
                m_sq[i] = 0;
                m_en[i] = 0;
            end else if (eld) begin
                m_sq[i] = (int'(ed) > MODS[i] - 1) ? MODS[i] - 1 : int'(ed);
                m_en[i] = 0;
            end else if (eena) begin
                m_en[i]++;
                if (m_en[i] == DIVS[i]) begin
                    m_en[i]   = 0;
                    m_tick[i] = 1;
                    if (up) begin
                        m_tc[i] = (m_sq[i] == MODS[i] - 1) ? 1 : 0;
`ifdef UPME_SAT_EN
                        if (m_tc[i] == 0) m_sq[i] = m_sq[i] + 1;
`else
                        m_sq[i] = (m_sq[i] + 1) % MODS[i];
`endif
                    end else begin
                        m_tc[i] = (m_sq[i] == 0) ? 1 : 0;
`ifdef UPME_SAT_EN
                        if (m_tc[i] == 0) m_sq[i] = m_sq[i] - 1;
`else
                        m_sq[i] = (m_sq[i] + MODS[i] - 1) % MODS[i];
`endif
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("sq[%0d]", i),   int'(sq_o[i]),   m_sq[i]);
            check($sformatf("tick[%0d]", i), int'(tick_o[i]), m_tick[i]);
            check($sformatf("tc[%0d]", i),   int'(tc_o[i]),   m_tc[i]);
            check($sformatf("oea[%0d]", i),  int'(oea_o[i]),  (int'(up) << W) | m_sq[i]);
        end
    endtask

    // One clock: wait for the edge, let outputs settle, advance the model and compare.
    task automatic cycle();
        @(posedge eck);
        #1;
        model_edge();
        compare_all();
    endtask

    initial begin
        // Async reset from power-up, before any clock edge.
        #1 er = 1'b1;
        #1;
        model_reset();
        compare_all();
        cycle();
        cycle();
        er   = 1'b0;
        eena = 1'b1;
        up   = 1'b1;

        // Free-running up count: 40 enabled cycles from reset release.
        for (int k = 0; k < 40; k++) cycle();
        check("sq0_after_40", int'(sq_o[0]), 2);

        // Reset mid-count between edges: outputs must clear without a clock.
        for (int k = 0; k < 3; k++) cycle();
        #3 er = 1'b1;
        #1;
        model_reset();
        check("async_sq0",   int'(sq_o[0]),   0);
        check("async_tick2", int'(tick_o[2]), 0);
        check("async_tc2",   int'(tc_o[2]),   0);
        compare_all();
        cycle();
        er = 1'b0;

        // Randomized mix of enable gaps, direction changes and loads.
        for (int k = 0; k < 600; k++) begin
            cycle();
            eena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) up = ~up;
            eld  = ($urandom_range(0, 19) == 0);
            ed   = W'($urandom_range(0, 7));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
